fir_engine_ctrl: RTL and testbench
==================================

// Module: fir_engine_ctrl
// PURPOSE
//  Sequencer for the user-project FIR engine behind the Wishbone/AXI bridge: runs the ap_start/ap_done/ap_idle
//  protocol, takes x[n] off the AXI-Stream input, keeps the data BRAM as a circular shift buffer, and steps one
//  shared MAC over TAPS coefficients per sample. Each y[n] goes out on AXI-Stream. The MAC and both BRAMs sit outside.
// PARAMETERS
//  TAPS     11   number of coefficients (>=2); tap and data BRAM depth in words
//  DW       32   sample / coefficient / accumulator width
//  AW       12   BRAM byte-address width; addresses = word_index<<2
// PORTS
//  wb_clk_i     in   1   single clock, all logic rising-edge
//  wb_rst_i     in   1   asynchronous, active-high reset
//  ap_start     in   1   one-cycle start pulse from config register
//  ap_done_rd   in   1   one-cycle pulse: host read the ap_done register (clear-on-read)
//  data_length  in   32  number of samples to process; sampled on accepted ap_start
//  ap_idle      out  1   engine idle, ready for ap_start
//  ap_done      out  1   run complete; sticky until ap_done_rd
//  ss_tvalid    in   1   input stream valid
//  ss_tdata     in   DW  input sample x[n]
//  ss_tlast     in   1   input last marker
//  ss_tready    out  1   input accepted when ss_tvalid & ss_tready
//  tap_EN       out  1   tap BRAM enable
//  tap_A        out  AW  tap BRAM byte address (read only; 1-cycle synchronous read)
//  data_EN      out  1   data BRAM enable
//  data_WE      out  4   data BRAM byte write enables
//  data_A       out  AW  data BRAM byte address
//  data_Di      out  DW  data BRAM write data
//  mac_clr      out  1   MAC: load product instead of accumulating (first product)
//  mac_en       out  1   MAC: product of this cycle's BRAM read data is valid
//  mac_acc      in   DW  MAC accumulator value (registered, valid cycle after last mac_en)
//  sm_tvalid    out  1   output stream valid
//  sm_tdata     out  DW  y[n], held stable while sm_tvalid & !sm_tready
//  sm_tlast     out  1   high with the data_length-th output
//  sm_tready    in   1   output stream ready
// BEHAVIOUR
//  Reset (async): state IDLE; ap_idle=1; every other output 0; ptr=0, cnt=0.
//  IDLE: ap_idle=1. ap_start -> CLR; latch data_length. ap_start in any other state is ignored.
//  CLR: TAPS cycles, data_EN=1, data_WE=4'hF, data_Di=0, data_A=i<<2 for i=0..TAPS-1; ap_idle=0. -> WAIT_IN,
//       or -> DONE if data_length==0.
//  WAIT_IN: ss_tready=1. On handshake write ss_tdata at data_A=ptr<<2 (WE=4'hF) same cycle -> MAC, k=0.
//  MAC: cycle k (0..TAPS-1): tap_A=k<<2, data_A=((ptr-k) mod TAPS)<<2, EN=1, WE=0. mac_en asserted cycle k+1
//       (read latency); mac_clr with the first mac_en. After mac_en for k=TAPS-1 -> ACC (1 cycle: mac_acc settles).
//  ACC: latch mac_acc into sm_tdata -> OUT. Latency: ss handshake to sm_tvalid = TAPS+3 cycles.
//  OUT: sm_tvalid=1; sm_tlast=(cnt==len-1). On sm_tready: cnt++, ptr=(ptr==TAPS-1)?0:ptr+1;
//       last -> DONE else -> WAIT_IN. Back-pressure: hold all outputs indefinitely.
//  DONE: ap_done=1, ap_idle=0. On ap_done_rd -> IDLE (ap_done=0, ap_idle=1 next cycle).
//  ss_tready never high outside WAIT_IN; only one sample in flight. Address arithmetic mod TAPS, no overflow.
//  Reset mid-run: abandon immediately, BRAM contents don't care (CLR re-zeroes on next start).
// CONFIGURATION
//  FIR_TLAST_CHECK_EN defined: extra output err_tlast (1b, sticky, cleared by accepted ap_start), set when
//    ss_tlast disagrees with (cnt==len-1) on an accepted input. Undefined: port absent, ss_tlast ignored.
// STRUCTURE
//  fir_ctrl_pkg: state enum (IDLE,CLR,WAIT_IN,MAC,ACC,OUT,DONE), BYTE_SHIFT=2, WE_ALL=4'hF.
//  Sub-module fir_circ_addr: modulo-TAPS (ptr-k) address generator, combinational, instanced once.
// TESTING
//  Taps {0,-10,-9,23,56,63,56,23,-9,-10,0}, x[n]=n+1, len=5, sm_tready=1 -> y=0,-10,-29,-25,35; tlast on 5th.
//  Same run, sm_tready low 20 cycles on 2nd output -> sm_tdata stays -10, ss_tready stays 0, no samples lost.
//  len=0 -> CLR then ap_done=1 with no ss_tready; ap_done held until ap_done_rd, then ap_idle=1.
//  Back-to-back runs, len=12 (ptr wraps past 10) -> second run matches first (CLR cleared history).
//  ap_start pulses during MAC and DONE -> ignored; wb_rst_i mid-MAC -> next cycle all outputs 0, ap_idle=1.
//  FIR_TLAST_CHECK_EN: ss_tlast on sample 3 of len=5 -> err_tlast=1 until next ap_start.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fir_ctrl_pkg
//   Shared definitions for the FIR engine sequencer:
//     fir_state_e  - sequencer states (IDLE, CLR, WAIT_IN, MAC, ACC, OUT, DONE)
//     BYTE_SHIFT   - word index to BRAM byte address shift (32-bit words)
//     WE_ALL       - full-word byte write enable
//     idx_width()  - width of a counter that must reach TAPS inclusive
// -----------------------------------------------------------------------------
package fir_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLR     = 3'd1,
        WAIT_IN = 3'd2,
        MAC     = 3'd3,
        ACC     = 3'd4,
        OUT     = 3'd5,
        DONE    = 3'd6
    } fir_state_e;

    localparam int         BYTE_SHIFT = 2;
    localparam logic [3:0] WE_ALL     = 4'hF;

    // The MAC step counter runs one past the last tap (drain cycle), so it
    // must be able to hold the value TAPS itself.
    function automatic int idx_width(input int taps);
        return $clog2(taps + 1);
    endfunction

endpackage

// File: rtl/fir_circ_addr.sv
// -----------------------------------------------------------------------------
// fir_circ_addr
//   Combinational circular-buffer address generator for the data BRAM.
//   Returns the byte address of word ((ptr - k) mod TAPS), i.e. the sample
//   that arrived k samples before the one at ptr.
//   Ports:
//     ptr   in  IW  current write pointer (0..TAPS-1)
//     k     in  IW  tap index (0..TAPS; TAPS only occurs on the drain cycle,
//                   where the address is not used)
//     addr  out AW  data BRAM byte address
// -----------------------------------------------------------------------------
module fir_circ_addr
    import fir_ctrl_pkg::*;
#(
    parameter int TAPS = 11,
    parameter int IW   = 4,
    parameter int AW   = 12
) (
    input  logic [IW-1:0] ptr,
    input  logic [IW-1:0] k,
    output logic [AW-1:0] addr
);

    localparam int            XW     = IW + 1;
    localparam logic [XW-1:0] TAPS_X = XW'(TAPS);

    logic [XW-1:0] ptr_x;
    logic [XW-1:0] k_x;
    logic [XW-1:0] idx;

    assign ptr_x = {1'b0, ptr};
    assign k_x   = {1'b0, k};

    // Both operands are below TAPS+1, so a single conditional add of TAPS
    // is enough to fold a negative difference back into range.
    always_comb begin
        idx = '0;
        if (ptr_x >= k_x) begin
            idx = ptr_x - k_x;
        end else begin
            idx = ptr_x + TAPS_X - k_x;
        end
    end

    assign addr = AW'(idx) << BYTE_SHIFT;

endmodule

// File: rtl/fir_engine_ctrl.sv
// -----------------------------------------------------------------------------
// fir_engine_ctrl
//   Sequencer for the FIR engine. Runs the ap_start/ap_done/ap_idle protocol,
//   accepts x[n] on the AXI-Stream slave, maintains the data BRAM as a
//   circular history buffer, steps an external MAC over TAPS coefficients per
//   sample and emits y[n] on the AXI-Stream master. MAC and BRAMs are external.
//
//   Ports:
//     wb_clk_i, wb_rst_i         clock, asynchronous active-high reset
//     ap_start, ap_done_rd       start pulse, ap_done clear-on-read pulse
//     data_length                samples per run (latched on accepted start)
//     ap_idle, ap_done           status
//     ss_tvalid/tdata/tlast/tready   input stream
//     tap_EN, tap_A              coefficient BRAM read port
//     data_EN/WE/A/Di            data BRAM port
//     mac_clr, mac_en, mac_acc   external MAC control / result
//     sm_tvalid/tdata/tlast/tready   output stream
//
//   Build option FIR_TLAST_CHECK_EN: adds err_tlast, a sticky flag set when
//   ss_tlast disagrees with the expected last sample, cleared on the next
//   accepted ap_start. Without it ss_tlast is ignored.
// -----------------------------------------------------------------------------
module fir_engine_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int TAPS = 11,
    parameter int DW   = 32,
    parameter int AW   = 12
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          ap_start,
    input  logic          ap_done_rd,
    input  logic [31:0]   data_length,
    output logic          ap_idle,
    output logic          ap_done,
`ifdef FIR_TLAST_CHECK_EN
    output logic          err_tlast,
`endif
    input  logic          ss_tvalid,
    input  logic [DW-1:0] ss_tdata,
    input  logic          ss_tlast,
    output logic          ss_tready,
    output logic          tap_EN,
    output logic [AW-1:0] tap_A,
    output logic          data_EN,
    output logic [3:0]    data_WE,
    output logic [AW-1:0] data_A,
    output logic [DW-1:0] data_Di,
    output logic          mac_clr,
    output logic          mac_en,
    input  logic [DW-1:0] mac_acc,
    output logic          sm_tvalid,
    output logic [DW-1:0] sm_tdata,
    output logic          sm_tlast,
    input  logic          sm_tready
);

    localparam int            IW     = idx_width(TAPS);
    localparam logic [IW-1:0] LAST_K = IW'(TAPS - 1);
    localparam logic [IW-1:0] DRAIN_K = IW'(TAPS);
    localparam logic [IW-1:0] ONE_K  = IW'(1);

    fir_state_e    state_q, state_d;
    logic [IW-1:0] k_q, k_d;          // CLR word index / MAC tap index
    logic [IW-1:0] ptr_q, ptr_d;      // newest sample slot in the data BRAM
    logic [31:0]   cnt_q, cnt_d;      // outputs delivered this run
    logic [31:0]   len_q, len_d;
    logic [DW-1:0] sm_tdata_q, sm_tdata_d;
    logic          mac_en_q, mac_en_d;
    logic          mac_clr_q, mac_clr_d;

    logic          is_last;
    logic          mac_rd;
    logic [AW-1:0] circ_a;

`ifdef FIR_TLAST_CHECK_EN
    logic          err_q, err_d;
`else
    logic          tlast_unused;
    assign tlast_unused = ss_tlast;
`endif

    // Current sample is the final one of the run. Only consulted in states
    // that are unreachable with len_q == 0, so the wrap of len_q-1 is harmless.
    assign is_last = (cnt_q == len_q - 32'd1);

    // Reads are issued for k = 0..TAPS-1; k = TAPS is the drain cycle where
    // the product of the last read is being accumulated.
    assign mac_rd = (state_q == MAC) && (k_q != DRAIN_K);

    fir_circ_addr #(
        .TAPS (TAPS),
        .IW   (IW),
        .AW   (AW)
    ) u_circ_addr (
        .ptr  (ptr_q),
        .k    (k_q),
        .addr (circ_a)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        sm_tdata_d = sm_tdata_q;
        mac_en_d   = 1'b0;
        mac_clr_d  = 1'b0;
`ifdef FIR_TLAST_CHECK_EN
        err_d      = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d = CLR;
                    len_d   = data_length;
                    k_d     = '0;
                    cnt_d   = '0;
                    ptr_d   = '0;
`ifdef FIR_TLAST_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            CLR: begin
                if (k_q == LAST_K) begin
                    k_d     = '0;
                    state_d = (len_q == 32'd0) ? DONE : WAIT_IN;
                end else begin
                    k_d = k_q + ONE_K;
                end
            end
            WAIT_IN: begin
                if (ss_tvalid) begin
                    state_d = MAC;
                    k_d     = '0;
`ifdef FIR_TLAST_CHECK_EN
                    if (ss_tlast != is_last) begin
                        err_d = 1'b1;
                    end
`endif
                end
            end
            MAC: begin
                // BRAM read latency is one cycle: the product for tap k is
                // valid in the cycle after its address was presented.
                mac_en_d  = mac_rd;
                mac_clr_d = (k_q == '0);
                if (k_q == DRAIN_K) begin
                    state_d = ACC;
                end else begin
                    k_d = k_q + ONE_K;
                end
            end
            ACC: begin
                sm_tdata_d = mac_acc;
                state_d    = OUT;
            end
            OUT: begin
                if (sm_tready) begin
                    cnt_d   = cnt_q + 32'd1;
                    ptr_d   = (ptr_q == LAST_K) ? '0 : ptr_q + ONE_K;
                    state_d = is_last ? DONE : WAIT_IN;
                end
            end
            DONE: begin
                if (ap_done_rd) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            k_q        <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            sm_tdata_q <= '0;
            mac_en_q   <= 1'b0;
            mac_clr_q  <= 1'b0;
`ifdef FIR_TLAST_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            sm_tdata_q <= sm_tdata_d;
            mac_en_q   <= mac_en_d;
            mac_clr_q  <= mac_clr_d;
`ifdef FIR_TLAST_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only, except the input-sample
    // write, which must land in the handshake cycle itself.
    // ------------------------------------------------------------------
    assign ap_idle   = (state_q == IDLE);
    assign ap_done   = (state_q == DONE);
    assign ss_tready = (state_q == WAIT_IN);
    assign sm_tvalid = (state_q == OUT);
    assign sm_tlast  = (state_q == OUT) && is_last;
    assign sm_tdata  = sm_tdata_q;
    assign mac_en    = mac_en_q;
    assign mac_clr   = mac_clr_q;
    assign tap_EN    = mac_rd;
    assign tap_A     = mac_rd ? (AW'(k_q) << BYTE_SHIFT) : '0;
`ifdef FIR_TLAST_CHECK_EN
    assign err_tlast = err_q;
`endif

    always_comb begin
        data_EN = 1'b0;
        data_WE = 4'h0;
        data_A  = '0;
        data_Di = '0;
        unique case (state_q)
            CLR: begin
                data_EN = 1'b1;
                data_WE = WE_ALL;
                data_A  = AW'(k_q) << BYTE_SHIFT;
            end
            WAIT_IN: begin
                if (ss_tvalid) begin
                    data_EN = 1'b1;
                    data_WE = WE_ALL;
                    data_A  = AW'(ptr_q) << BYTE_SHIFT;
                    data_Di = ss_tdata;
                end
            end
            MAC: begin
                if (mac_rd) begin
                    data_EN = 1'b1;
                    data_A  = circ_a;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_fir_engine_ctrl.sv
// Directed bench for fir_engine_ctrl with behavioural tap/data BRAMs and MAC.
module tb_fir_engine_ctrl;

    localparam int TAPS = 11;
    localparam int DW   = 32;
    localparam int AW   = 12;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i;
    logic          ap_start, ap_done_rd;
    logic [31:0]   data_length;
    logic          ap_idle, ap_done;
    logic          ss_tvalid, ss_tlast, ss_tready;
    logic [DW-1:0] ss_tdata;
    logic          tap_EN, data_EN, mac_clr, mac_en;
    logic [AW-1:0] tap_A, data_A;
    logic [3:0]    data_WE;
    logic [DW-1:0] data_Di, mac_acc, sm_tdata;
    logic          sm_tvalid, sm_tlast, sm_tready;
`ifdef FIR_TLAST_CHECK_EN
    logic          err_tlast;
`endif

    fir_engine_ctrl #(.TAPS(TAPS), .DW(DW), .AW(AW)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .ap_start    (ap_start),
        .ap_done_rd  (ap_done_rd),
        .data_length (data_length),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
`ifdef FIR_TLAST_CHECK_EN
        .err_tlast   (err_tlast),
`endif
        .ss_tvalid   (ss_tvalid),
        .ss_tdata    (ss_tdata),
        .ss_tlast    (ss_tlast),
        .ss_tready   (ss_tready),
        .tap_EN      (tap_EN),
        .tap_A       (tap_A),
        .data_EN     (data_EN),
        .data_WE     (data_WE),
        .data_A      (data_A),
        .data_Di     (data_Di),
        .mac_clr     (mac_clr),
        .mac_en      (mac_en),
        .mac_acc     (mac_acc),
        .sm_tvalid   (sm_tvalid),
        .sm_tdata    (sm_tdata),
        .sm_tlast    (sm_tlast),
        .sm_tready   (sm_tready)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // ---------------- external models ----------------
    int          taps [TAPS] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    // y[n] for x[n]=n+1, worked out by hand
    int          yref [12]   = '{0, -10, -29, -25, 35, 158, 337, 539, 732, 915, 1098, 1281};
    logic [31:0] dmem [TAPS];
    logic [31:0] tap_do, data_do, acc;

    always @(posedge wb_clk_i) begin
        if (tap_EN) tap_do <= taps[int'(tap_A >> 2)];
        if (data_EN) begin
            data_do <= dmem[int'(data_A >> 2)];
            if (data_WE == 4'hF) dmem[int'(data_A >> 2)] <= data_Di;
        end
        if (mac_en) acc <= mac_clr ? tap_do * data_do : acc + tap_do * data_do;
    end
    assign mac_acc = acc;

    int n_den, n_ten, n_clr, n_rdy, n_abad;
    always @(negedge wb_clk_i) begin
        if (data_EN) n_den++;
        if (tap_EN) n_ten++;
        if (mac_clr) n_clr++;
        if (ss_tready) n_rdy++;
        if (data_EN && int'(data_A >> 2) >= TAPS) n_abad++;
    end

    // ---------------- checking ----------------
    int checks = 0, failures = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    logic [31:0] got  [16];
    logic [31:0] save [16];
    logic        gotl [16];
    int n_in, n_out, lat, hold_bad, rdy_stall, n_stall, timed_out;

    // One complete run: start, feed x[n]=n+1, collect y[n], stop on ap_done.
    // stall_out: output index held off for 20 cycles (-1: none).
    // bad_last : 1-based sample carrying a wrong ss_tlast (0: none).
    // poke     : pulse ap_start while the first sample is in MAC.
    task automatic run(input int len, input int stall_out, input int bad_last, input bit poke);
        int hs0, first_v, stall_left;
        logic [31:0] prev;
        n_in = 0; n_out = 0; hold_bad = 0; rdy_stall = 0; n_stall = 0; timed_out = 0;
        hs0 = -1; first_v = -1; stall_left = 20; prev = '0;
        n_den = 0; n_ten = 0; n_clr = 0; n_rdy = 0; n_abad = 0;
        data_length = len; ap_start = 1'b1;
        @(posedge wb_clk_i); #1;
        ap_start  = 1'b0;
        ss_tvalid = (len > 0);
        ss_tdata  = 32'd1;
        ss_tlast  = (len == 1) || (bad_last == 1);
        sm_tready = 1'b1;
        for (int cyc = 0; ; cyc++) begin
            if (ap_done) break;
            if (cyc == 3000) begin timed_out = 1; break; end
            @(negedge wb_clk_i);
            if (ss_tvalid && ss_tready) begin
                if (n_in == 0) hs0 = cyc;
                n_in++;
            end
            if (sm_tvalid && first_v < 0) first_v = cyc;
            if (sm_tvalid && !sm_tready) begin
                if (n_stall == 0) prev = sm_tdata;
                else if (sm_tdata !== prev) hold_bad++;
                if (ss_tready) rdy_stall++;
                n_stall++;
            end
            if (sm_tvalid && sm_tready && n_out < 16) begin
                got[n_out]  = sm_tdata;
                gotl[n_out] = sm_tlast;
                n_out++;
            end
            @(posedge wb_clk_i); #1;
            ss_tvalid = (n_in < len);
            ss_tdata  = n_in + 1;
            ss_tlast  = (n_in == len - 1) || (n_in + 1 == bad_last);
            sm_tready = !(sm_tvalid && n_out == stall_out && stall_left > 0);
            if (!sm_tready) stall_left--;
            ap_start  = poke && hs0 >= 0 && cyc == hs0 + 3;
        end
        ap_start  = 1'b0;
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
        lat = first_v - hs0;
        chk("run_timeout", timed_out, 0);
    endtask

    task automatic done_ack();
        ap_done_rd = 1'b1;
        @(posedge wb_clk_i); #1;
        ap_done_rd = 1'b0;
    endtask

    function automatic logic [8:0] status();
        return {ap_idle, ap_done, ss_tready, sm_tvalid, sm_tlast, tap_EN, data_EN, mac_en, mac_clr};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wb_rst_i = 1'b1; ap_start = 0; ap_done_rd = 0; data_length = 0;
        ss_tvalid = 0; ss_tdata = 0; ss_tlast = 0; sm_tready = 0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        chk("rst_status", 32'(status()), 32'h100);
        chk("rst_bus", 32'(|{tap_A, data_A, data_Di, data_WE, sm_tdata}), 0);
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;

        // A: len=5, no back-pressure
        run(5, -1, 0, 0);
        chk("a_nout", n_out, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("a_y%0d", i), got[i], yref[i]);
        chk("a_tlast4", gotl[4], 1);
        chk("a_tlast_early", {gotl[0], gotl[1], gotl[2], gotl[3]}, 0);
        chk("a_latency", lat, TAPS + 3);
        chk("a_data_en", n_den, TAPS + 5 * (TAPS + 1));
        chk("a_tap_en", n_ten, 5 * TAPS);
        chk("a_mac_clr", n_clr, 5);
        chk("a_addr_range", n_abad, 0);
        chk("a_rdy_cycles", n_rdy, 5);
`ifdef FIR_TLAST_CHECK_EN
        chk("a_err_tlast", err_tlast, 0);
`endif
        // ap_start in DONE is ignored
        ap_start = 1'b1; @(posedge wb_clk_i); #1; ap_start = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        chk("done_start_ign", {ap_done, ap_idle}, 2'b10);
        done_ack();
        chk("a_ack_idle", {ap_done, ap_idle}, 2'b01);

        // B: 20-cycle stall on the 2nd output
        run(5, 1, 0, 0);
        chk("b_nout", n_out, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("b_y%0d", i), got[i], yref[i]);
        chk("b_stall_cyc", n_stall, 20);
        chk("b_hold", hold_bad, 0);
        chk("b_stall_val", got[1], 32'hFFFF_FFF6);
        chk("b_rdy_stall", rdy_stall, 0);
        chk("b_nin", n_in, 5);
        done_ack();

        // C: len=0 -> CLR only, then DONE held until read
        run(0, -1, 0, 0);
        chk("c_rdy", n_rdy, 0);
        chk("c_clr_writes", n_den, TAPS);
        chk("c_nout", n_out, 0);
        repeat (10) @(posedge wb_clk_i);
        #1;
        chk("c_done_held", {ap_done, ap_idle}, 2'b10);
        done_ack();
        chk("c_idle", {ap_done, ap_idle}, 2'b01);

        // D: back-to-back len=12 (pointer wraps), second run pokes ap_start in MAC
        run(12, -1, 0, 0);
        chk("d1_nout", n_out, 12);
        for (int i = 0; i < 12; i++) chk($sformatf("d1_y%0d", i), got[i], yref[i]);
        chk("d1_tlast", gotl[11], 1);
        for (int i = 0; i < 12; i++) save[i] = got[i];
        done_ack();
        run(12, -1, 0, 1);
        chk("d2_nout", n_out, 12);
        for (int i = 0; i < 12; i++) chk($sformatf("d2_y%0d", i), got[i], save[i]);
        chk("d2_addr_range", n_abad, 0);
        done_ack();

        // E: reset in the middle of MAC
        data_length = 5; ap_start = 1'b1;
        @(posedge wb_clk_i); #1;
        ap_start = 1'b0; ss_tvalid = 1'b1; ss_tdata = 32'd1;
        for (int i = 0; i < 50 && !ss_tready; i++) begin
            @(posedge wb_clk_i); #1;
        end
        chk("e_wait_rdy", ss_tready, 1);
        @(posedge wb_clk_i); #1;
        ss_tvalid = 1'b0;
        repeat (4) @(posedge wb_clk_i);
        #1;
        chk("e_mid_mac", tap_EN, 1);
        wb_rst_i = 1'b1;
        #1;
        chk("e_rst_status", 32'(status()), 32'h100);
        chk("e_rst_bus", 32'(|{tap_A, data_A, data_Di, data_WE, sm_tdata}), 0);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;
        run(5, -1, 0, 0);
        for (int i = 0; i < 5; i++) chk($sformatf("e_y%0d", i), got[i], yref[i]);
        done_ack();

`ifdef FIR_TLAST_CHECK_EN
        // F: premature ss_tlast on sample 3
        run(5, -1, 3, 0);
        chk("f_err_set", err_tlast, 1);
        done_ack();
        chk("f_err_sticky", err_tlast, 1);
        run(5, -1, 0, 0);
        chk("f_err_clr", err_tlast, 0);
        done_ack();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
